// File: rtl/instr_pkg.sv
// Shared types for the instruction issue buffer: opcode encoding, occupancy
// classes and the opcode field extractor for default-width instruction words.
package instr_pkg;

  localparam int unsigned INSTR_W_DEFAULT = 8;
  localparam int unsigned OP_W            = 2;

  typedef enum logic [OP_W-1:0] {
    OP_MOV  = 2'b00,
    OP_ADDI = 2'b01,
    OP_NOP  = 2'b10,
    OP_JMP  = 2'b11
  } opcode_e;

  // Occupancy class of the buffer, derived from the entry count
  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_SINGLE,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  // Opcode lives in the top OP_W bits of the instruction word
  function automatic opcode_e opcode_of(input logic [INSTR_W_DEFAULT-1:0] instr);
    return opcode_e'(instr[INSTR_W_DEFAULT-1 -: OP_W]);
  endfunction

endpackage

// File: rtl/instr_issue_buffer_if.sv
// Bundle between the instruction loader / decode stage and the issue buffer.
//   Write side : in_valid, in_ready, in_instr
//   Read side  : advance, flush, out_valid, out_instr, opcode, next_opcode
//   Optional   : issue_count (only when ISSUE_CNT_EN is defined)
// Modports: slave = the buffer itself, master = the surrounding environment.
interface instr_issue_buffer_if
  import instr_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEFAULT
);

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               advance;
  logic               flush;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  opcode_e            opcode;
  opcode_e            next_opcode;
`ifdef ISSUE_CNT_EN
  logic [15:0]        issue_count;
`endif

  modport slave (
`ifdef ISSUE_CNT_EN
    output issue_count,
`endif
    input  in_valid, in_instr, advance, flush,
    output in_ready, out_valid, out_instr, opcode, next_opcode
  );

  modport master (
`ifdef ISSUE_CNT_EN
    input  issue_count,
`endif
    output in_valid, in_instr, advance, flush,
    input  in_ready, out_valid, out_instr, opcode, next_opcode
  );

endinterface

// File: rtl/instr_issue_buffer.sv
// Ring-buffer FIFO feeding the decode stage: accepts instructions with
// valid/ready, presents the head word, its opcode and the opcode of the entry
// behind it (lookahead). advance pops the head, flush empties the buffer.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : instr_issue_buffer_if.slave (see interface header)
// Build option: ISSUE_CNT_EN adds a 16-bit wrapping count of accepted pops.
module instr_issue_buffer
  import instr_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEFAULT,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_issue_buffer_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   rd_nxt_c;
  logic [CNT_W-1:0]   count_q, count_d;
  occ_e               occ_c;
  logic               push_c;
  logic               pop_c;

  // Occupancy class from count
  always_comb begin
    occ_c = OCC_PARTIAL;
    if (count_q == '0)                 occ_c = OCC_EMPTY;
    else if (count_q == CNT_W'(1))     occ_c = OCC_SINGLE;
    else if (count_q == FULL_CNT)      occ_c = OCC_FULL;
  end

  assign bus.in_ready  = (occ_c != OCC_FULL);
  assign bus.out_valid = (occ_c != OCC_EMPTY);
  assign push_c        = bus.in_valid & bus.in_ready;
  assign pop_c         = bus.advance & bus.out_valid;

  // Next-state for pointers and count; flush wins over push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; empty slots are masked at the outputs
  always_ff @(posedge clk) begin
    if (push_c && !bus.flush) mem_q[wr_ptr_q] <= bus.in_instr;
  end

  // Head and lookahead presentation
  assign rd_nxt_c        = rd_ptr_q + PTR_W'(1);
  assign bus.out_instr   = bus.out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.opcode      = bus.out_valid
                           ? opcode_e'(mem_q[rd_ptr_q][INSTR_W-1 -: OP_W])
                           : OP_NOP;
  assign bus.next_opcode = (occ_c == OCC_PARTIAL || occ_c == OCC_FULL)
                           ? opcode_e'(mem_q[rd_nxt_c][INSTR_W-1 -: OP_W])
                           : OP_NOP;

`ifdef ISSUE_CNT_EN
  logic [15:0] issue_cnt_q;

  // Counts pops that take effect; a pop swallowed by flush is not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    issue_cnt_q <= '0;
    else if (pop_c && !bus.flush)  issue_cnt_q <= issue_cnt_q + 16'd1;
  end

  assign bus.issue_count = issue_cnt_q;
`endif

endmodule
